// File: rtl/decode_pkg.sv
// Shared constants, field positions and the decoded output bundle
// for the decode stage.
package decode_pkg;

  localparam int DATA_W = 16;
  localparam int IMM_W  = 5;
  localparam int NREGS  = 8;
  localparam int REG_W  = 3;
  localparam int OPC_W  = 4;

  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_BR  = 4'hC;

  localparam int OPC_LSB  = 12;
  localparam int IMMF_BIT = 11;
  localparam int RD_LSB   = 8;
  localparam int RS1_LSB  = 5;
  localparam int RS2_LSB  = 2;
  localparam int IMM_LSB  = 0;
  localparam int BOFF_W   = 12;

  localparam logic [DATA_W-1:0] REG_PAT = 16'h1111;

  typedef struct packed {
    logic [IMM_W-1:0]  imm;
    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-1:0] branch_target;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } dec_out_t;

  function automatic logic [DATA_W-1:0] sext_imm(
    input logic [IMM_W-1:0] v
  );
    return {{(DATA_W-IMM_W){v[IMM_W-1]}}, v};
  endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch-to-decode control/instruction inputs and the
// registered decode results.
interface decode_if
  import decode_pkg::*;
();

  logic              stall;
  logic              is_branch_taken;
  logic [DATA_W-1:0] instr;
  logic [IMM_W-1:0]  imm;
  logic [OPC_W-1:0]  opcode;
  logic [DATA_W-1:0] branch_target;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;

  modport master (
    output stall, is_branch_taken, instr,
    input  imm, opcode, branch_target, op1, op2
  );

  modport slave (
    input  stall, is_branch_taken, instr,
    output imm, opcode, branch_target, op1, op2
  );

endinterface

// File: rtl/decode_regfile.sv
// Read-only register array with fixed contents R[i] = i * 16'h1111
// and two combinational read ports.
module decode_regfile
  import decode_pkg::*;
(
  input  logic [REG_W-1:0]  rs1_i,
  input  logic [REG_W-1:0]  rs2_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o
);

  logic [DATA_W-1:0] regs [NREGS];

  // Constant register contents.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs[i] = DATA_W'(i) * REG_PAT;
    end
  end

  // Two asynchronous read ports.
  always_comb begin
    rd1_o = regs[rs1_i];
    rd2_o = regs[rs2_i];
  end

endmodule

// File: rtl/decode_unit.sv
// Instruction decode stage: field extraction, operand read and
// branch target, all behind one output register.
module decode_unit
  import decode_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  decode_if.slave bus
);

  logic [OPC_W-1:0]  opc;
  logic              immf;
  logic [REG_W-1:0]  rs1;
  logic [REG_W-1:0]  rs2;
  logic [IMM_W-1:0]  immv;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  dec_out_t          dec;
  dec_out_t          out_d;
  dec_out_t          out_q;

  assign opc  = bus.instr[OPC_LSB +: OPC_W];
  assign immf = bus.instr[IMMF_BIT];
  assign rs1  = bus.instr[RS1_LSB +: REG_W];
  assign rs2  = bus.instr[RS2_LSB +: REG_W];
  assign immv = bus.instr[IMM_LSB +: IMM_W];

  decode_regfile u_rf (
    .rs1_i (rs1),
    .rs2_i (rs2),
    .rd1_o (rd1),
    .rd2_o (rd2)
  );

  // Decode the current instruction word.
  always_comb begin
    dec = '0;
    unique case (1'b1)
      (opc == OP_NOP): begin
        dec = '0;
      end
      (opc == OP_BR): begin
        dec.opcode        = opc;
        dec.branch_target = {
          {(DATA_W-BOFF_W){bus.instr[BOFF_W-1]}},
          bus.instr[BOFF_W-1:0]
        };
      end
      default: begin
        dec.opcode = opc;
        dec.op1    = rd1;
        dec.op2    = immf ? sext_imm(immv) : rd2;
        dec.imm    = immf ? immv : '0;
      end
    endcase
  end

  // Flush beats stall; stall holds the previous decode.
  always_comb begin
    out_d = out_q;
    if (bus.is_branch_taken) begin
      out_d = '0;
    end else if (!bus.stall) begin
      out_d = dec;
    end
  end

  // Output register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.imm           = out_q.imm;
  assign bus.opcode        = out_q.opcode;
  assign bus.branch_target = out_q.branch_target;
  assign bus.op1           = out_q.op1;
  assign bus.op2           = out_q.op2;

endmodule

// File: tb/tb_decode_unit.sv
// Scoreboard bench for decode_unit: expected decodes are queued
// when stimulus is driven and compared one edge later.
module tb_decode_unit;

  typedef struct {
    logic [4:0]  imm;
    logic [3:0]  opcode;
    logic [15:0] bt;
    logic [15:0] op1;
    logic [15:0] op2;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];
  exp_t model_q;

  decode_if bus ();

  decode_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(
    input string tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rval(input logic [2:0] r);
    return {4{{1'b0, r}}};
  endfunction

  function automatic exp_t decode(input logic [15:0] i);
    exp_t e;
    e.imm = '0; e.opcode = '0; e.bt = '0;
    e.op1 = '0; e.op2 = '0;
    if (i[15:12] == 4'h0) begin
      return e;
    end else if (i[15:12] == 4'hC) begin
      e.opcode = 4'hC;
      e.bt = {{4{i[11]}}, i[11:0]};
    end else begin
      e.opcode = i[15:12];
      e.op1 = rval(i[7:5]);
      if (i[11]) begin
        e.imm = i[4:0];
        e.op2 = {{11{i[4]}}, i[4:0]};
      end else begin
        e.op2 = rval(i[4:2]);
      end
    end
    return e;
  endfunction

  task automatic step(
    input string tag,
    input logic r,
    input logic s,
    input logic f,
    input logic [15:0] i
  );
    exp_t e;
    exp_t z;
    z = decode(16'h0000);
    @(negedge clk);
    reset = r;
    bus.stall = s;
    bus.is_branch_taken = f;
    bus.instr = i;
    if (r || f) model_q = z;
    else if (!s) model_q = decode(i);
    sb_q.push_back(model_q);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 16'd1, 16'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, ".opcode"}, 16'(bus.opcode), 16'(e.opcode));
      check({tag, ".imm"}, 16'(bus.imm), 16'(e.imm));
      check({tag, ".bt"}, bus.branch_target, e.bt);
      check({tag, ".op1"}, bus.op1, e.op1);
      check({tag, ".op2"}, bus.op2, e.op2);
    end
  endtask

  initial begin
    logic [15:0] ri;
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.is_branch_taken = 1'b0;
    bus.instr = 16'h2290;
    model_q = decode(16'h0000);

    step("reset", 1, 0, 0, 16'h2290);
    step("nop", 0, 0, 0, 16'h0000);
    step("imm1911", 0, 0, 0, 16'h1911);
    step("reg2290", 0, 0, 0, 16'h2290);
    step("brC123", 0, 0, 0, 16'hC123);
    step("brC800", 0, 0, 0, 16'hC800);
    step("pre2290", 0, 0, 0, 16'h2290);
    step("flush", 0, 0, 1, 16'h2290);
    step("unflush", 0, 0, 0, 16'h2290);
    step("stl_fl", 0, 1, 1, 16'h2290);
    step("pre1911", 0, 0, 0, 16'h1911);
    for (int k = 0; k < 3; k++) begin
      step("stall", 0, 1, 0, 16'h2290);
    end
    step("release", 0, 0, 0, 16'h2290);
    step("alu7", 0, 0, 0, 16'h7BFF);
    step("rst_stl", 1, 1, 0, 16'h1911);
    step("post_rst", 0, 0, 0, 16'hF8EF);
    step("rst_fl", 1, 0, 1, 16'h2290);

    for (int k = 0; k < 60; k++) begin
      ri = 16'($urandom);
      step("rand", 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 5) == 0), ri);
    end

    check("sb_drain", 16'(sb_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
